reorder_buffer: RTL

- 16-entry in-order reorder buffer.
- Allocates ROB positions to instructions issued by the Decoder and collects results from the ALU and LSB writeback buses.
- Retires one instruction per cycle to the Register module through the commit interface (rd, value, rob_pos) and asserts rollback on a branch mispredict.
- Answers combinational operand queries from the Decoder for renamed registers.

---
 rtl/reorder_buffer_pkg.sv | 30 +++
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/reorder_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants, issue-type codes and the per-entry payload record.
package reorder_buffer_pkg;

  localparam int unsigned ROB_POS_W = 4;
  localparam int unsigned ROB_SIZE  = 2 ** ROB_POS_W;
  localparam int unsigned CNT_W     = ROB_POS_W + 1;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;

  typedef enum logic [1:0] {
    TYPE_ALU  = 2'd0,
    TYPE_BR   = 2'd1,
    TYPE_ST   = 2'd2,
    TYPE_JALR = 2'd3
  } issue_type_e;

  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [CNT_W-1:0]     rob_cnt_t;

  typedef struct packed {
    issue_type_e      itype;
    logic [REG_W-1:0] rd;
    logic             pred_jump;
    logic             jump;
    logic [XLEN-1:0]  val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder / writeback / commit bundle around the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             issue;
  issue_type_e      issue_type;
  logic [REG_W-1:0] issue_rd;
  logic             issue_pred_jump;
  logic             issue_ready;
  logic [XLEN-1:0]  issue_val;
  logic [XLEN-1:0]  issue_pc;
  rob_pos_t         tail_pos;
  logic             rob_full;

  logic             alu_wb;
  rob_pos_t         alu_wb_pos;
  logic [XLEN-1:0]  alu_wb_val;
  logic             alu_wb_jump;
  logic [XLEN-1:0]  alu_wb_pc;
  logic             lsb_wb;
  rob_pos_t         lsb_wb_pos;
  logic [XLEN-1:0]  lsb_wb_val;

  rob_pos_t         q1_pos;
  logic             q1_ready;
  logic [XLEN-1:0]  q1_val;
  rob_pos_t         q2_pos;
  logic             q2_ready;
  logic [XLEN-1:0]  q2_val;

  logic             commit;
  logic [REG_W-1:0] commit_rd;
  logic [XLEN-1:0]  commit_val;
  rob_pos_t         commit_rob_pos;
  logic             commit_store;
  logic             rollback;
  logic [XLEN-1:0]  rollback_pc;

  modport master (
    output issue, issue_type, issue_rd, issue_pred_jump, issue_ready, issue_val, issue_pc,
    output alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump, alu_wb_pc,
    output lsb_wb, lsb_wb_pos, lsb_wb_val, q1_pos, q2_pos,
    input  tail_pos, rob_full, q1_ready, q1_val, q2_ready, q2_val,
    input  commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, rollback_pc
  );

  modport slave (
    input  issue, issue_type, issue_rd, issue_pred_jump, issue_ready, issue_val, issue_pc,
    input  alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump, alu_wb_pc,
    input  lsb_wb, lsb_wb_pos, lsb_wb_val, q1_pos, q2_pos,
    output tail_pos, rob_full, q1_ready, q1_val, q2_ready, q2_val,
    output commit, commit_rd, commit_val, commit_rob_pos, commit_store, rollback, rollback_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: allocate, collect writebacks, retire one
// per cycle, flush on branch mispredict or jalr, answer operand queries.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  reorder_buffer_if.slave bus
);

  rob_pos_t            head;
  rob_pos_t            tail;
  rob_cnt_t            count;
  logic [ROB_SIZE-1:0] valid;
  logic [ROB_SIZE-1:0] ready;
  rob_entry_t          entry [ROB_SIZE];

  rob_entry_t      head_e;
  logic            full_c;
  logic            issue_ok_c;
  logic            alu_ok_c;
  logic            lsb_ok_c;
  logic            retire_c;
  logic            flush_c;
  logic [XLEN-1:0] redirect_c;
  logic [REG_W-1:0] retire_rd_c;
  logic [XLEN-1:0] retire_val_c;

  // Head-of-buffer retire decision and redirect target
  always_comb begin
    head_e       = entry[head];
    full_c       = (count == rob_cnt_t'(ROB_SIZE));
    issue_ok_c   = bus.issue && !full_c;
    alu_ok_c     = bus.alu_wb && valid[bus.alu_wb_pos];
    lsb_ok_c     = bus.lsb_wb && valid[bus.lsb_wb_pos];
    retire_c     = valid[head] && ready[head];
    flush_c      = retire_c && ((head_e.itype == TYPE_BR && head_e.jump != head_e.pred_jump)
                                || head_e.itype == TYPE_JALR);
    redirect_c   = (head_e.itype == TYPE_JALR || head_e.jump) ? head_e.target
                                                              : head_e.pc + 32'd4;
    retire_rd_c  = (head_e.itype == TYPE_BR || head_e.itype == TYPE_ST) ? '0 : head_e.rd;
    retire_val_c = (head_e.itype == TYPE_JALR) ? head_e.pc + 32'd4 : head_e.val;
  end

  assign bus.tail_pos = tail;
  assign bus.rob_full = full_c;

  // Operand queries with same-cycle writeback bypass (ALU wins ties)
  always_comb begin
    bus.q1_ready = 1'b0;
    bus.q1_val   = '0;
    bus.q2_ready = 1'b0;
    bus.q2_val   = '0;
    if (valid[bus.q1_pos]) begin
      if (bus.alu_wb && bus.alu_wb_pos == bus.q1_pos) begin
        bus.q1_ready = 1'b1;
        bus.q1_val   = bus.alu_wb_val;
      end else if (bus.lsb_wb && bus.lsb_wb_pos == bus.q1_pos) begin
        bus.q1_ready = 1'b1;
        bus.q1_val   = bus.lsb_wb_val;
      end else if (ready[bus.q1_pos]) begin
        bus.q1_ready = 1'b1;
        bus.q1_val   = entry[bus.q1_pos].val;
      end
    end
    if (valid[bus.q2_pos]) begin
      if (bus.alu_wb && bus.alu_wb_pos == bus.q2_pos) begin
        bus.q2_ready = 1'b1;
        bus.q2_val   = bus.alu_wb_val;
      end else if (bus.lsb_wb && bus.lsb_wb_pos == bus.q2_pos) begin
        bus.q2_ready = 1'b1;
        bus.q2_val   = bus.lsb_wb_val;
      end else if (ready[bus.q2_pos]) begin
        bus.q2_ready = 1'b1;
        bus.q2_val   = entry[bus.q2_pos].val;
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (rdy && !flush_c) begin
      if (issue_ok_c) begin
        entry[tail] <= '{itype:     bus.issue_type,
                         rd:        bus.issue_rd,
                         pred_jump: bus.issue_pred_jump,
                         jump:      1'b0,
                         val:       bus.issue_val,
                         pc:        bus.issue_pc,
                         target:    '0};
      end
      if (alu_ok_c) begin
        entry[bus.alu_wb_pos].val    <= bus.alu_wb_val;
        entry[bus.alu_wb_pos].jump   <= bus.alu_wb_jump;
        entry[bus.alu_wb_pos].target <= bus.alu_wb_pc;
      end
      if (lsb_ok_c) begin
        entry[bus.lsb_wb_pos].val <= bus.lsb_wb_val;
      end
    end
  end

  // Pointers, occupancy, status bits and registered commit/rollback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      valid              <= '0;
      ready              <= '0;
      bus.commit         <= 1'b0;
      bus.commit_store   <= 1'b0;
      bus.commit_rd      <= '0;
      bus.commit_val     <= '0;
      bus.commit_rob_pos <= '0;
      bus.rollback       <= 1'b0;
      bus.rollback_pc    <= '0;
    end else if (!rdy) begin
      bus.commit       <= 1'b0;
      bus.commit_store <= 1'b0;
      bus.rollback     <= 1'b0;
    end else begin
      bus.commit       <= retire_c;
      bus.commit_store <= retire_c && head_e.itype == TYPE_ST;
      bus.rollback     <= flush_c;
      if (retire_c) begin
        bus.commit_rd      <= retire_rd_c;
        bus.commit_val     <= retire_val_c;
        bus.commit_rob_pos <= head;
      end
      if (flush_c) begin
        bus.rollback_pc <= redirect_c;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        valid           <= '0;
        ready           <= '0;
      end else begin
        if (issue_ok_c) begin
          valid[tail] <= 1'b1;
          ready[tail] <= bus.issue_ready;
          tail        <= tail + rob_pos_t'(1);
        end
        if (alu_ok_c) ready[bus.alu_wb_pos] <= 1'b1;
        if (lsb_ok_c) ready[bus.lsb_wb_pos] <= 1'b1;
        if (retire_c) begin
          valid[head] <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + rob_pos_t'(1);
        end
        count <= count + rob_cnt_t'(issue_ok_c) - rob_cnt_t'(retire_c);
      end
    end
  end

endmodule
